// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART datapath (receive and transmit sides).
//   DATA_BITS             : payload bits per frame (8N1 framing)
//   DEFAULT_CLKS_PER_BIT  : clock cycles per bit for 115200 baud at 100 MHz
//   rx_state_t            : receive FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input. The reset value is a
// parameter so idle-high lines (UART RX) and idle-low inputs can share it.
// Ports:
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised output, two clk_i cycles of latency
// ----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values; a blocking chain would collapse into a single stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receiver. Recovers frames from the raw RX pin and presents each
// byte on a valid/ready interface, with one-cycle pulses for framing errors
// and for bytes dropped because the holding register was still occupied.
// The serial side never stalls: a byte that cannot be stored is dropped.
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_rx         : raw serial line, idle high, asynchronous to i_clk
//   o_data       : received byte, stable while o_valid is high
//   o_valid      : byte available, held until accepted
//   i_ready      : consumer accepts the byte when o_valid && i_ready
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_overrun    : one-cycle pulse, completed byte dropped (register full)
//   o_busy       : FSM is not idle
// ----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Terminal counts: the bit-time counter runs 0 .. target-1.
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Input synchronisation and edge history
  // --------------------------------------------------------------------------
  logic rx_s;
  logic rx_prev_q;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_rx),
    .q_o    (rx_s)
  );

  // Previous synchronised sample, reset high so a line held low through
  // reset is not mistaken for a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rx_prev_q <= 1'b1;
    else          rx_prev_q <= rx_s;
  end

  // --------------------------------------------------------------------------
  // FSM and datapath registers
  // --------------------------------------------------------------------------
  rx_state_t            state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;
  logic                 ovr_q,    ovr_d;
  logic                 commit;

  // NOTE: the shift register and data holding register are reset along with
  // the control state; they are tiny, and a defined o_data after reset is
  // part of the interface contract.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    commit  = 1'b0;

    // Consumer handshake: the byte leaves on the cycle after acceptance.
    if (valid_q && i_ready) valid_d = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A line already back high at mid start bit was a glitch.
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};  // LSB arrives first
          if (idx_q == IDX_LAST) state_d = RX_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Hold off until the line returns high so a long break cannot
      // retrigger a stream of false frames.
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end

      default: state_d = RX_IDLE;
    endcase

    // Commit succeeds if the holding register is empty or is being emptied
    // in this very cycle; otherwise the new byte is dropped.
    if (commit) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != RX_IDLE);

  // A presented byte must stay put until the consumer takes it.
  a_hold_until_accepted : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      (valid_q && !i_ready) |=> (valid_q && $stable(data_q))
  );

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Cycles from the line falling (driven on a negedge) to the first cycle the
  // registered outputs show the frame result: 2 sync + HALF + 9 bits + 1.
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Scoreboard and monitor statistics (monotonic; tests use deltas).
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int         cyc          = 0;
  int         hs_cnt       = 0;
  int         valid_cycles = 0;
  int         busy_cycles  = 0;
  int         ferr_cycles  = 0;
  int         ovr_cycles   = 0;
  int         valid_rise   = 0;
  int         ferr_rise    = 0;
  logic       valid_prev   = 1'b0;
  logic       ferr_prev    = 1'b0;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overrun   (ovr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 2 ns after each negedge, pops the scoreboard on every
  // handshake.
  initial forever begin
    @(negedge clk);
    #2;
    if (valid) valid_cycles++;
    if (busy)  busy_cycles++;
    if (ferr)  ferr_cycles++;
    if (ovr)   ovr_cycles++;
    if (valid && !valid_prev) valid_rise = cyc;
    if (ferr && !ferr_prev)   ferr_rise  = cyc;
    valid_prev = valid;
    ferr_prev  = ferr;
    if (valid && ready) begin
      hs_cnt++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_byte: got 0x%02h, expected no byte", data);
      end else begin
        exp_byte = exp_q.pop_front();
        if (data !== exp_byte)
          $display("FAIL byte_value: got 0x%02h, expected 0x%02h", data, exp_byte);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called and returning on a negedge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got 0x%02h, expected 0x00", data); else pass_cnt++;
    check_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", valid); else pass_cnt++;
    check_cnt++; if (ferr !== 1'b0)  $display("FAIL reset_frame_err: got %b, expected 0", ferr); else pass_cnt++;
    check_cnt++; if (ovr !== 1'b0)   $display("FAIL reset_overrun: got %b, expected 0", ovr); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b, expected 0", busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int hs0, v0, b0, f0, start;
    hs0 = hs_cnt; v0 = valid_cycles; b0 = busy_cycles; f0 = ferr_cycles;
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    start = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    check_cnt++; if (hs_cnt - hs0 !== 1) $display("FAIL basic_delivered: got %0d bytes, expected 1", hs_cnt - hs0); else pass_cnt++;
    check_cnt++; if (valid_cycles - v0 !== 1) $display("FAIL basic_valid_width: got %0d cycles, expected 1", valid_cycles - v0); else pass_cnt++;
    check_cnt++; if (valid_rise - start !== LAT) $display("FAIL basic_latency: got %0d cycles, expected %0d", valid_rise - start, LAT); else pass_cnt++;
    check_cnt++; if (ferr_cycles - f0 !== 0) $display("FAIL basic_frame_err: got %0d pulses, expected 0", ferr_cycles - f0); else pass_cnt++;
    check_cnt++;
    if (busy_cycles - b0 < 9 * CPB || busy_cycles - b0 > 10 * CPB)
      $display("FAIL basic_busy_len: got %0d cycles, expected %0d..%0d", busy_cycles - b0, 9 * CPB, 10 * CPB);
    else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b, expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_overrun();
    int hs0, o0;
    hs0 = hs_cnt; o0 = ovr_cycles;
    ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    check_cnt++; if (valid !== 1'b1) $display("FAIL ovr_valid_held: got %b, expected 1", valid); else pass_cnt++;
    check_cnt++; if (data !== 8'h3C) $display("FAIL ovr_data_held: got 0x%02h, expected 0x3c", data); else pass_cnt++;
    check_cnt++; if (ovr_cycles - o0 !== 1) $display("FAIL ovr_pulse: got %0d cycles, expected 1", ovr_cycles - o0); else pass_cnt++;
    @(negedge clk);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check_cnt++; if (valid !== 1'b0) $display("FAIL ovr_valid_drop: got %b, expected 0", valid); else pass_cnt++;
    check_cnt++; if (hs_cnt - hs0 !== 1) $display("FAIL ovr_delivered: got %0d bytes, expected 1", hs_cnt - hs0); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int hs0, v0, f0, start;
    hs0 = hs_cnt; v0 = valid_cycles; f0 = ferr_cycles;
    ready = 1'b1;
    start = cyc;
    send_frame(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    #2;
    check_cnt++; if (ferr_cycles - f0 !== 1) $display("FAIL ferr_pulse: got %0d cycles, expected 1", ferr_cycles - f0); else pass_cnt++;
    check_cnt++; if (ferr_rise - start !== LAT) $display("FAIL ferr_latency: got %0d cycles, expected %0d", ferr_rise - start, LAT); else pass_cnt++;
    check_cnt++; if (valid_cycles - v0 !== 0) $display("FAIL ferr_no_valid: got %0d cycles, expected 0", valid_cycles - v0); else pass_cnt++;
    check_cnt++; if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b, expected 1", busy); else pass_cnt++;
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_cnt++; if (busy !== 1'b0) $display("FAIL ferr_break_exit: got %b, expected 0", busy); else pass_cnt++;
    @(negedge clk);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    check_cnt++; if (hs_cnt - hs0 !== 1) $display("FAIL ferr_recover: got %0d bytes, expected 1", hs_cnt - hs0); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int v0, b0, f0, o0;
    v0 = valid_cycles; b0 = busy_cycles; f0 = ferr_cycles; o0 = ovr_cycles;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (HALF + 3 - 5) @(negedge clk);
    #2;
    check_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_low: got %b, expected 0", busy); else pass_cnt++;
    check_cnt++;
    if (busy_cycles - b0 < 1 || busy_cycles - b0 > HALF + 3)
      $display("FAIL glitch_busy_len: got %0d cycles, expected 1..%0d", busy_cycles - b0, HALF + 3);
    else pass_cnt++;
    repeat (12 * CPB) @(negedge clk);
    #2;
    check_cnt++; if (valid_cycles - v0 !== 0) $display("FAIL glitch_no_valid: got %0d cycles, expected 0", valid_cycles - v0); else pass_cnt++;
    check_cnt++;
    if (ferr_cycles - f0 !== 0 || ovr_cycles - o0 !== 0)
      $display("FAIL glitch_no_error: got ferr=%0d ovr=%0d, expected 0/0", ferr_cycles - f0, ovr_cycles - o0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int hs0;
    hs0 = hs_cnt;
    ready = 1'b1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_cnt++; if (data !== 8'h00) $display("FAIL midrst_data: got 0x%02h, expected 0x00", data); else pass_cnt++;
        check_cnt++; if (valid !== 1'b0) $display("FAIL midrst_valid: got %b, expected 0", valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0)  $display("FAIL midrst_busy: got %b, expected 0", busy); else pass_cnt++;
        check_cnt++;
        if (ferr !== 1'b0 || ovr !== 1'b0) $display("FAIL midrst_pulses: got ferr=%b ovr=%b, expected 0/0", ferr, ovr);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    check_cnt++; if (hs_cnt - hs0 !== 1) $display("FAIL midrst_only_new: got %0d bytes, expected 1", hs_cnt - hs0); else pass_cnt++;
  endtask

  task automatic test_ready_at_commit();
    int hs0, o0;
    hs0 = hs_cnt; o0 = ovr_cycles;
    ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    fork
      send_frame(8'h34, 1'b1);
      begin
        // Land i_ready on the cycle whose closing edge registers the commit.
        repeat (LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        #2;
        check_cnt++; if (valid !== 1'b1) $display("FAIL commit_valid: got %b, expected 1", valid); else pass_cnt++;
        check_cnt++; if (data !== 8'h34) $display("FAIL commit_data: got 0x%02h, expected 0x34", data); else pass_cnt++;
      end
    join
    repeat (4) @(negedge clk);
    #2;
    check_cnt++; if (ovr_cycles - o0 !== 0) $display("FAIL commit_no_overrun: got %0d cycles, expected 0", ovr_cycles - o0); else pass_cnt++;
    check_cnt++; if (hs_cnt - hs0 !== 2) $display("FAIL commit_delivered: got %0d bytes, expected 2", hs_cnt - hs0); else pass_cnt++;
    check_cnt++; if (valid !== 1'b0) $display("FAIL commit_drained: got %b, expected 0", valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_ready_at_commit();
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d pending bytes, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_uart_rx_core

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front end for the UART datapath. Recovers 8N1 frames from the asynchronous input pin into bytes presented on a valid/ready interface. It sits upstream of the transmit path, so received bytes can be looped back, buffered, or used to drive the LED logic. It flags framing errors and overruns and never blocks the serial line.

## Interface
- CLKS_PER_BIT, 868: `i_clk` cycles per bit (100 MHz / 115200). Must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division): delay from detected start edge to the start-bit centre check.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx  in  1  raw serial line; idle high; asynchronous to `i_clk`.
- o_data  out  8  received byte; stable while `o_valid` is high.
- o_valid  out  1  byte available; held until accepted.
- i_ready  in  1  consumer accepts the byte when `o_valid && i_ready`.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: a completed byte was dropped because the holding register was still full.
- o_busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: `i_rx` passes through a 2-FF synchroniser with reset value 1. All further logic uses only the synchronised line `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: a falling edge on `rx_s` (previous sample 1, current sample 0) clears the bit counter and moves to START.
- START: counts HALF_BIT cycles, then samples `rx_s`.
  - If the sample is 0, clear the counter and go to DATA.
  - If the sample is 1, this is a false start: return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, sample `rx_s` into a shift register, LSB first. After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - If the sample is 1, the frame is complete: do the output commit, then go to IDLE.
  - If the sample is 0, pulse `o_frame_err`, discard the byte, and go to BREAK.
- BREAK: wait for `rx_s` == 1, then go to IDLE. This stops a held-low line from retriggering.
- Output commit:
  - If `o_valid` is 0, or `o_valid && i_ready` in the commit cycle: load `o_data` and set `o_valid`.
  - Otherwise: keep the old byte and pulse `o_overrun`.
- Handshake: `o_valid` clears on the cycle after `o_valid && i_ready`, unless a commit happens in that same cycle, in which case it stays high with the new data. `o_data` does not change while `o_valid` is high and not accepted.
- Counters:
  - Bit-time counter width is $clog2(CLKS_PER_BIT).
  - It counts from 0 up to the target minus 1, then clears on each sample.
  - Bit index is 3 bits and does not wrap past 7.

## Timing
- Reset values: `o_data` = 0x00, `o_valid` = 0, `o_frame_err` = 0, `o_overrun` = 0, `o_busy` = 0, FSM = IDLE, synchroniser = 1.
- Reset mid-frame aborts immediately. Any partial byte is lost and no pulse is generated.
- Synchroniser latency is 2 cycles.
- Sample points, measured from the first cycle `rx_s` is low:
  - start-bit check at HALF_BIT;
  - data bit k at HALF_BIT + (k+1)·CLKS_PER_BIT;
  - stop bit at HALF_BIT + 9·CLKS_PER_BIT.
- `o_valid`, `o_frame_err` and `o_overrun` change in the cycle after the stop sample, i.e. they are registered.
- Back-to-back frames with no idle gap are received without loss, because IDLE can detect the next start edge in the cycle after the STOP commit.
- A start-bit glitch shorter than HALF_BIT is rejected.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - the DATA_BITS = 8 constant;
  - the default CLKS_PER_BIT constant, shared with the TX side.
- Sub-module `uart_sync2`: a parameterised-reset-value 2-FF synchroniser, also reusable for other asynchronous inputs.
- Everything else lives in one FSM/datapath module.

## Test plan
All scenarios run with CLKS_PER_BIT = 16.
- Send 0xA5 with `i_ready` tied 1 → `o_valid` pulses for 1 cycle with `o_data` = 0xA5; `o_frame_err` = 0; `o_busy` is high for about 10 bit times.
- Send 0x3C then 0xC3 back-to-back with `i_ready` = 0 → `o_data` stays 0x3C, `o_valid` stays high, and `o_overrun` pulses once. Then raise `i_ready` → `o_valid` drops and no further byte appears.
- Send 0x55 with the stop bit forced low, then hold the line low for 3 bit times → one `o_frame_err` pulse, no `o_valid`, and the FSM stays in BREAK until the line goes high. A following 0x0F is then received correctly.
- Drive a 5-cycle low glitch on an idle line → no `o_valid`, no error, and `o_busy` returns low by cycle HALF_BIT + 3.
- Assert `i_rst_n` low in the middle of the DATA phase of 0xFF, release it, then send 0x81 → all outputs read their reset values during reset, and only 0x81 is delivered.
- Send 0x12 with `i_ready` = 0, then assert `i_ready` in exactly the commit cycle of the next byte 0x34 → `o_valid` stays high, `o_data` = 0x34, and no overrun is reported.
